// File: rtl/cg_memory_pipe.sv
// cg_memory_pipe
// ---------------------------------------------------------------------------
// Behavioural word memory with one write channel and one read channel, both
// valid/ready. Writes honour byte-lane strobes. Reads are sampled from the
// array on the accepting edge and pass through READ_LATENCY-1 register stages
// into an OUT_DEPTH-entry output FIFO. A credit counter covers every read in
// the pipeline plus every buffered beat, so the FIFO can never overflow even
// when the consumer holds off rdata. o_raddr_ready is a flop, so it has no
// combinational path from i_rdata_ready.
//
// Optional feature: define CG_MEMORY_PIPE_OOR_EN to flag out-of-range
// addresses (nonzero bits above the index width). OOR writes are dropped, and
// OOR reads return zero data with o_rerr=1. Without the macro the upper
// address bits are ignored (addresses wrap) and o_rerr is constant 0.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_wdata_valid / o_wdata_ready   write handshake
//   i_waddr, i_wdata, i_wstrb       write word address, data, byte enables
//   i_raddr_valid / o_raddr_ready   read-address handshake
//   i_raddr                         read word address
//   o_rdata_valid / i_rdata_ready   read-data handshake
//   o_rdata, o_rerr                 read data beat and its error flag
// ---------------------------------------------------------------------------
module cg_memory_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int WORD_NUM     = 1024,
    parameter int READ_LATENCY = 1,
    parameter int OUT_DEPTH    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wdata_valid,
    output logic                      o_wdata_ready,
    input  logic [ADDR_WIDTH-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    input  logic                      i_raddr_valid,
    output logic                      o_raddr_ready,
    input  logic [ADDR_WIDTH-1:0]     i_raddr,
    output logic                      o_rdata_valid,
    input  logic                      i_rdata_ready,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_rerr
);

    localparam int IDX_W  = $clog2(WORD_NUM);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

    // Storage array; intentionally not reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [WORD_NUM];

    logic                  wdata_ready_q, wdata_ready_d;
    logic                  raddr_ready_q, raddr_ready_d;
    logic [CNT_W-1:0]      credit_q, credit_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [OUT_DEPTH];
    logic                  fifo_err_q  [OUT_DEPTH];
    logic                  fifo_err_d  [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;
    logic                  waddr_hi_nz;
    logic                  raddr_hi_nz;
    logic                  w_oor;
    logic                  r_oor;
    logic                  wr_en;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_err;
    logic                  fifo_pop;

    assign w_idx = i_waddr[IDX_W-1:0];
    assign r_idx = i_raddr[IDX_W-1:0];

    // Detect address bits above the memory index range.
    generate
        if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
            assign waddr_hi_nz = |i_waddr[ADDR_WIDTH-1:IDX_W];
            assign raddr_hi_nz = |i_raddr[ADDR_WIDTH-1:IDX_W];
        end else begin : g_no_addr_hi
            assign waddr_hi_nz = 1'b0;
            assign raddr_hi_nz = 1'b0;
        end
    endgenerate

`ifdef CG_MEMORY_PIPE_OOR_EN
    assign w_oor = waddr_hi_nz;
    assign r_oor = raddr_hi_nz;
`else
    // Upper address bits wrap; they are deliberately left unconsumed.
    logic unused_addr_hi;
    assign unused_addr_hi = waddr_hi_nz | raddr_hi_nz;
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    // Writes need the registered ready and a live reset, so a write presented
    // on the edge where reset asserts is never performed.
    assign wr_en     = i_wdata_valid & wdata_ready_q & i_rst_n & ~w_oor;
    assign rd_accept = i_raddr_valid & raddr_ready_q;

    // The array is read combinationally before the same-edge write lands,
    // which gives read-before-write on an address collision.
    assign rd_data = r_oor ? '0 : mem[r_idx];
    assign rd_err  = r_oor;

    // Byte-lane write into the array.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Latency pipeline: with READ_LATENCY=1 the sampled word goes straight
    // into the FIFO on the accepting edge; otherwise it rides READ_LATENCY-1
    // stages and is pushed on the last one.
    generate
        if (READ_LATENCY == 1) begin : g_no_pipe
            assign push_valid = rd_accept;
            assign push_data  = rd_data;
            assign push_err   = rd_err;
        end else begin : g_pipe
            localparam int STAGES = READ_LATENCY - 1;
            logic [STAGES-1:0]     stage_valid_q, stage_valid_d;
            logic [STAGES-1:0]     stage_err_q, stage_err_d;
            logic [DATA_WIDTH-1:0] stage_data_q [STAGES];
            logic [DATA_WIDTH-1:0] stage_data_d [STAGES];

            // Shift each stage forward every cycle; stage 0 takes the new read.
            always_comb begin
                stage_valid_d[0] = rd_accept;
                stage_err_d[0]   = rd_err;
                stage_data_d[0]  = rd_data;
                for (int k = 1; k < STAGES; k++) begin
                    stage_valid_d[k] = stage_valid_q[k-1];
                    stage_err_d[k]   = stage_err_q[k-1];
                    stage_data_d[k]  = stage_data_q[k-1];
                end
            end

            // Stage registers; reset clears in-flight reads.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    stage_valid_q <= '0;
                    stage_err_q   <= '0;
                    for (int k = 0; k < STAGES; k++) begin
                        stage_data_q[k] <= '0;
                    end
                end else begin
                    stage_valid_q <= stage_valid_d;
                    stage_err_q   <= stage_err_d;
                    stage_data_q  <= stage_data_d;
                end
            end

            assign push_valid = stage_valid_q[STAGES-1];
            assign push_data  = stage_data_q[STAGES-1];
            assign push_err   = stage_err_q[STAGES-1];
        end
    endgenerate

    assign fifo_pop = (fifo_cnt_q != '0) & i_rdata_ready;

    // Output FIFO update and credit accounting. Credits track pipeline plus
    // FIFO occupancy, so raddr_ready can be computed from the next count and
    // registered without looking at the consumer combinationally.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_valid) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_err_d[wr_ptr_q]  = push_err;
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push_valid) - CNT_W'(fifo_pop);
        credit_d      = credit_q + CNT_W'(rd_accept) - CNT_W'(fifo_pop);
        raddr_ready_d = (credit_d < CNT_W'(OUT_DEPTH));
        wdata_ready_d = 1'b1;
    end

    // Control state: handshake readies, credits and FIFO pointers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdata_ready_q <= 1'b0;
            raddr_ready_q <= 1'b0;
            credit_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            wdata_ready_q <= wdata_ready_d;
            raddr_ready_q <= raddr_ready_d;
            credit_q      <= credit_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // FIFO payload storage; validity comes from the count, so no reset.
    always_ff @(posedge i_clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_err_q  <= fifo_err_d;
    end

    // Data and error are forced to zero whenever no beat is presented.
    assign o_wdata_ready = wdata_ready_q;
    assign o_raddr_ready = raddr_ready_q;
    assign o_rdata_valid = (fifo_cnt_q != '0);
    assign o_rdata       = o_rdata_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign o_rerr        = o_rdata_valid ? fifo_err_q[rd_ptr_q] : 1'b0;

endmodule
